// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter between N_REQ byte producers, round-robin, one byte per grant.
// Latency: req seen in IDLE at edge k -> uart_transmit high in cycle k+1; ack one cycle after is_transmitting falls.
// Backpressure: producers hold req until ack; no grant while the uart reports is_transmitting.
//
// Ports:
//   clk, rst (async, active-high)
//   req[N_REQ], req_byte[8*N_REQ]     producer side, byte i on [8*i+7:8*i]
//   ack[N_REQ], grant_id, busy        producer status
//   uart_transmit, uart_tx_byte       to the uart transmit pins
//   uart_is_transmitting              from the uart
//   tx_error                          timeout abort pulse
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to abort a launch the uart never
// picks up within TIMEOUT cycles; otherwise tx_error is tied low and WAIT_ST waits forever.
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [8*N_REQ-1:0]         req_byte,
   output logic [N_REQ-1:0]           ack,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       uart_transmit,
   output logic [7:0]                 uart_tx_byte,
   input  logic                       uart_is_transmitting,
   output logic                       tx_error
);

   localparam int IDW = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ST,
      S_WAIT_END,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [IDW-1:0]   last_q;
   logic [IDW-1:0]   grant_q;
   logic [7:0]       byte_q;
   logic             busy_q;
   logic             xmit_q;
   logic [N_REQ-1:0] ack_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
`endif

   // Round-robin pick: first set request scanning last+1, last+2, ... mod N_REQ.
   // The modulo keeps unused indices of a non-power-of-2 N_REQ out of reach.
   logic             win_vld_d;
   logic [IDW-1:0]   win_idx_d;
   logic [IDW-1:0]   cand_d;

   always_comb begin
      win_vld_d = 1'b0;
      win_idx_d = '0;
      cand_d    = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_d = IDW'((int'(last_q) + i) % N_REQ);
         if (!win_vld_d && req[cand_d]) begin
            win_vld_d = 1'b1;
            win_idx_d = cand_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= IDW'(N_REQ - 1);
         grant_q <= '0;
         byte_q  <= 8'h00;
         busy_q  <= 1'b0;
         xmit_q  <= 1'b0;
         ack_q   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         // Pulse outputs default low; states below raise them for one cycle.
         xmit_q <= 1'b0;
         ack_q  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         err_q  <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               // A high is_transmitting means someone else owns the uart: hold off.
               if (win_vld_d && !uart_is_transmitting) begin
                  grant_q <= win_idx_d;
                  byte_q  <= req_byte[8*win_idx_d +: 8];
                  busy_q  <= 1'b1;
                  xmit_q  <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
               cnt_q   <= '0;
`endif
               state_q <= S_WAIT_ST;
            end
            S_WAIT_ST: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
               // cnt_q holds (cycles since LAUNCH) - 1, so the error pulse lands
               // exactly TIMEOUT cycles after the transmit pulse.
               if (uart_is_transmitting) begin
                  state_q <= S_WAIT_END;
               end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  last_q  <= grant_q;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
`else
               if (uart_is_transmitting) begin
                  state_q <= S_WAIT_END;
               end
`endif
            end
            S_WAIT_END: begin
               if (!uart_is_transmitting) begin
                  ack_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               last_q  <= grant_q;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack           = ack_q;
   assign grant_id      = grant_q;
   assign busy          = busy_q;
   assign uart_transmit = xmit_q;
   assign uart_tx_byte  = byte_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
   assign tx_error = err_q;
`else
   assign tx_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with N_REQ=4 and a behavioural uart transmitter model.
// Latency: n/a (testbench).
// Backpressure: the uart model holds is_transmitting high for FRAME cycles per launch.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int FRAME = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_byte;
   logic [N-1:0]  ack;
   logic [1:0]    grant_id;
   logic          busy;
   logic          uart_transmit;
   logic [7:0]    uart_tx_byte;
   logic          uart_is_transmitting;
   logic          tx_error;

   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   mcnt   = 0;
   logic [7:0] captured = 8'h00;
   logic uart_dead = 1'b0;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req                  (req),
      .req_byte             (req_byte),
      .ack                  (ack),
      .grant_id             (grant_id),
      .busy                 (busy),
      .uart_transmit        (uart_transmit),
      .uart_tx_byte         (uart_tx_byte),
      .uart_is_transmitting (uart_is_transmitting),
      .tx_error             (tx_error)
   );

   always #5 clk = ~clk;

   // Uart model: captures the byte on a transmit pulse and reports busy for FRAME edges.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         uart_is_transmitting <= 1'b0;
         mcnt                 <= 0;
      end else begin
         if (uart_transmit) pulses <= pulses + 1;
         if (uart_transmit && !uart_is_transmitting && !uart_dead) begin
            captured             <= uart_tx_byte;
            mcnt                 <= FRAME;
            uart_is_transmitting <= 1'b1;
         end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
         end else if (mcnt == 1) begin
            mcnt                 <= 0;
            uart_is_transmitting <= 1'b0;
         end
      end
   end

   typedef struct packed {
      logic        do_reset;
      logic        hold;      // 1: keep req level through all frames; 0: drop each bit on its ack
      logic [3:0]  req;
      logic [31:0] bytes;
      int          nfr;
      logic [23:0] ack_seq;   // frame f expected ack at [4*f +: 4]
      logic [47:0] byte_seq;  // frame f expected byte at [8*f +: 8]
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_ack(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   initial begin
      logic ok;
      int   p0;
      int   err_at;
      logic busy_after;
      logic saw_err;
      logic saw_ack;

      // f0 lives in the least-significant slot of each sequence.
      vecs[0] = '{1'b1, 1'b1, 4'b1111, 32'h44332211, 5,
                  {4'h0, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1},
                  {8'h00, 8'h11, 8'h44, 8'h33, 8'h22, 8'h11}};
      vecs[1] = '{1'b0, 1'b0, 4'b0001, 32'h443322A5, 1,
                  {20'h0, 4'h1}, {40'h0, 8'hA5}};
      vecs[2] = '{1'b0, 1'b0, 4'b0101, 32'h44332211, 2,
                  {16'h0, 4'h1, 4'h4}, {32'h0, 8'h11, 8'h33}};
      vecs[3] = '{1'b0, 1'b0, 4'b1010, 32'hDDCCBBAA, 2,
                  {16'h0, 4'h8, 4'h2}, {32'h0, 8'hDD, 8'hBB}};
      vecs[4] = '{1'b0, 1'b1, 4'b1000, 32'h99000000, 3,
                  {12'h0, 4'h8, 4'h8, 4'h8}, {24'h0, 8'h99, 8'h99, 8'h99}};
      vecs[5] = '{1'b1, 1'b0, 4'b0110, 32'h44332211, 2,
                  {16'h0, 4'h4, 4'h2}, {32'h0, 8'h33, 8'h22}};

      rst      = 1'b1;
      req      = '0;
      req_byte = '0;
      #12;
      check("rst_ack",      32'(ack),           32'h0);
      check("rst_grant",    32'(grant_id),      32'h0);
      check("rst_busy",     32'(busy),          32'h0);
      check("rst_transmit", 32'(uart_transmit), 32'h0);
      check("rst_txbyte",   32'(uart_tx_byte),  32'h0);
      check("rst_txerr",    32'(tx_error),      32'h0);
      tick();
      rst = 1'b0;

      // Table-driven arbitration / ordering vectors.
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].do_reset) apply_reset();
         req_byte = vecs[v].bytes;
         req      = vecs[v].req;
         for (int f = 0; f < vecs[v].nfr; f++) begin
            p0 = pulses;
            wait_ack(ok);
            check($sformatf("v%0d_f%0d_ack_seen", v, f), 32'(ok), 32'h1);
            check($sformatf("v%0d_f%0d_ack", v, f), 32'(ack), 32'(vecs[v].ack_seq[4*f +: 4]));
            check($sformatf("v%0d_f%0d_rxbyte", v, f), 32'(captured), 32'(vecs[v].byte_seq[8*f +: 8]));
            check($sformatf("v%0d_f%0d_txbyte", v, f), 32'(uart_tx_byte), 32'(vecs[v].byte_seq[8*f +: 8]));
            check($sformatf("v%0d_f%0d_grant", v, f), 32'(grant_id), 32'(oh2idx(vecs[v].ack_seq[4*f +: 4])));
            check($sformatf("v%0d_f%0d_pulses", v, f), 32'(pulses - p0), 32'h1);
            if (!vecs[v].hold) req = req & ~ack;
            else if (f == vecs[v].nfr - 1) req = '0;
            tick();
            check($sformatf("v%0d_f%0d_ack_1cyc", v, f), 32'(ack), 32'h0);
         end
         req = '0;
      end

      // Grant latency and late byte change ignored.
      apply_reset();
      req_byte = 32'h0000005A;
      req      = 4'b0001;
      tick();
      check("lat_transmit", 32'(uart_transmit), 32'h1);
      check("lat_busy",     32'(busy),          32'h1);
      tick();
      check("lat_pulse_end", 32'(uart_transmit), 32'h0);
      req_byte = 32'h000000FF;
      wait_ack(ok);
      check("late_ack_seen", 32'(ok),           32'h1);
      check("late_rxbyte",   32'(captured),     32'h5A);
      check("late_txbyte",   32'(uart_tx_byte), 32'h5A);
      req = '0;
      tick();

      // Reset while the frame is in flight, then a fresh frame from another requester.
      apply_reset();
      req_byte = 32'h00000077;
      req      = 4'b0001;
      ok       = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (uart_is_transmitting) begin
            ok = 1'b1;
            break;
         end
      end
      check("mid_started", 32'(ok), 32'h1);
      tick();
      tick();
      check("mid_busy", 32'(busy), 32'h1);
      req      = 4'b0010;
      req_byte = 32'h0000BB77;
      rst      = 1'b1;
      #1;
      check("mid_rst_busy",     32'(busy),          32'h0);
      check("mid_rst_ack",      32'(ack),           32'h0);
      check("mid_rst_transmit", 32'(uart_transmit), 32'h0);
      check("mid_rst_txbyte",   32'(uart_tx_byte),  32'h0);
      tick();
      rst = 1'b0;
      p0  = pulses;
      wait_ack(ok);
      check("post_rst_ack_seen", 32'(ok),         32'h1);
      check("post_rst_ack",      32'(ack),        32'h2);
      check("post_rst_rxbyte",   32'(captured),   32'hBB);
      check("post_rst_pulses",   32'(pulses - p0), 32'h1);
      req = '0;
      tick();

      // Uart never responds.
      apply_reset();
      uart_dead = 1'b1;
      req_byte  = 32'h00000042;
      req       = 4'b0001;
      tick();
      check("dead_launch", 32'(uart_transmit), 32'h1);
      err_at     = -1;
      busy_after = 1'b1;
      saw_err    = 1'b0;
      saw_ack    = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         tick();
         if (tx_error) begin
            saw_err = 1'b1;
            if (err_at < 0) err_at = c;
         end
         if (ack != '0) saw_ack = 1'b1;
         if (err_at > 0 && c == err_at + 1) busy_after = busy;
      end
      check("dead_no_ack", 32'(saw_ack), 32'h0);
`ifdef UART_TX_ARB_TIMEOUT_EN
      check("dead_err_at",     32'(err_at),     32'd64);
      check("dead_busy_after", 32'(busy_after), 32'h0);
`else
      check("dead_no_err",  32'(saw_err), 32'h0);
      check("dead_busy",    32'(busy),    32'h1);
`endif
      uart_dead = 1'b0;
      apply_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
